// File: rtl/image_uart_sender_pkg.sv
// Shared definitions for the image UART sender: FSM state encodings and
// UART frame constants. SENDER_CHECKSUM_EN adds the checksum-frame state.
package uart_pkg;

  localparam int       FRAME_BITS = 10;  // start + 8 data + stop
  localparam int       DATA_BITS  = 8;
  localparam logic     LINE_IDLE  = 1'b1;

`ifdef SENDER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_START_BIT,
    S_DATA_BITS,
    S_STOP_BIT,
    S_CKSUM_LOAD,
    S_FINISH
  } sender_state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_START_BIT,
    S_DATA_BITS,
    S_STOP_BIT,
    S_FINISH
  } sender_state_e;
`endif

  // Phase of the frame currently on the line, tracked by the shift core.
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_START,
    PH_DATA,
    PH_STOP
  } tx_phase_e;

endpackage

// File: rtl/image_uart_sender_if.sv
// RAM read port between the image sender (master) and the image RAM (slave).
// Handshake: the master pulses ram_rd_en for one cycle with ram_addr valid in
// that same cycle; the slave presents ram_q exactly RD_LAT cycles later. There
// is no back-pressure, and ram_q is don't-care in every other cycle.
interface image_uart_sender_if #(
  parameter int ADDR_W = 16
);

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd_en;
  logic [7:0]        ram_q;

  modport master (
    output ram_addr,
    output ram_rd_en,
    input  ram_q
  );

  modport slave (
    input  ram_addr,
    input  ram_rd_en,
    output ram_q
  );

endinterface

// File: rtl/image_uart_sender_tx_shift_core.sv
// 8N1 serializer: baud counter, bit counter and shift register. A load pulse
// starts a frame on the next edge; loading during the final cycle of a stop
// bit chains frames with no idle gap.
module tx_shift_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       tx_serial,
  output logic       tx_active,
  output logic       bit_tick,
  output logic       last_data_bit,
  output logic       frame_done,
  output tx_phase_e  phase_dbg
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  tx_phase_e         phase;
  tx_phase_e         phase_next;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;

  assign bit_tick      = (phase != PH_IDLE) && (baud_cnt == BAUD_LAST);
  assign last_data_bit = (phase == PH_DATA) && (bit_cnt == BIT_LAST);
  assign frame_done    = (phase == PH_STOP) && bit_tick;
  assign tx_active     = (phase != PH_IDLE);
  assign phase_dbg     = phase;

  // Frame phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_IDLE;
    end else begin
      phase <= phase_next;
    end
  end

  // Phase sequencing: start -> data x8 -> stop, then idle or the next start.
  always_comb begin
    phase_next = phase;
    case (phase)
      PH_IDLE:  if (load) phase_next = PH_START;
      PH_START: if (bit_tick) phase_next = PH_DATA;
      PH_DATA:  if (bit_tick && (bit_cnt == BIT_LAST)) phase_next = PH_STOP;
      PH_STOP:  if (bit_tick) phase_next = load ? PH_START : PH_IDLE;
      default:  phase_next = PH_IDLE;
    endcase
  end

  // Baud/bit counting and the registered line level (LSB first).
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx_serial <= LINE_IDLE;
    end else if (load) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= byte_in;
      tx_serial <= 1'b0;
    end else if (phase != PH_IDLE) begin
      if (bit_tick) begin
        baud_cnt <= '0;
        case (phase)
          PH_START: tx_serial <= shreg[0];
          PH_DATA: begin
            if (bit_cnt == BIT_LAST) begin
              tx_serial <= LINE_IDLE;
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              shreg     <= {1'b0, shreg[7:1]};
              tx_serial <= shreg[1];
            end
          end
          default: tx_serial <= LINE_IDLE;
        endcase
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end
    end
  end

endmodule

// File: rtl/image_uart_sender.sv
// Streams IMG_BYTES bytes from RAM address 0 upward out of a UART TX pin as
// back-to-back 8N1 frames, then pulses done. One byte is prefetched during
// each frame's data bits so the next start bit follows the stop bit directly.
// Optional macro SENDER_CHECKSUM_EN appends a frame with the mod-256 byte sum.
module image_uart_sender
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int ADDR_W       = 16,
  parameter int IMG_BYTES    = 16384,
  parameter int RD_LAT       = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  image_uart_sender_if.master ram,
  output logic                tx_serial,
  output logic                tx_active,
  output logic                busy,
  output logic                done,
  output sender_state_e       state_dbg,
  output tx_phase_e           phase_dbg
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_BYTES - 1);
  localparam logic [1:0]        LAT_LAST  = 2'(RD_LAT);

  sender_state_e     state;
  sender_state_e     state_next;
  logic [ADDR_W-1:0] addr;
  logic              fetched_last;
  logic              rd_pending;
  logic [1:0]        lat_cnt;
  logic              data_first;
  logic              pf_valid;
  logic [7:0]        pf_data;
  logic              rd_en;
  logic              capture;
  logic              load;
  logic [7:0]        load_byte;
  logic              bit_tick;
  logic              last_data_bit;
  logic              frame_done;
`ifdef SENDER_CHECKSUM_EN
  logic [7:0]        cksum;
  logic              cksum_load;
`endif

  // Read data is on ram_q in the RD_LAT-th cycle after the strobe.
  assign capture = rd_pending && (lat_cnt == LAT_LAST);

  tx_shift_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .byte_in      (load_byte),
    .tx_serial    (tx_serial),
    .tx_active    (tx_active),
    .bit_tick     (bit_tick),
    .last_data_bit(last_data_bit),
    .frame_done   (frame_done),
    .phase_dbg    (phase_dbg)
  );

  // FSM state register; reset overrides a coincident start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, read strobe and shift-core load selection.
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    load       = 1'b0;
    load_byte  = pf_data;
`ifdef SENDER_CHECKSUM_EN
    cksum_load = 1'b0;
`endif
    case (state)
      S_IDLE: if (start) state_next = S_PRIME;
      S_PRIME: begin
        rd_en = !rd_pending;
        if (capture) begin
          load       = 1'b1;
          load_byte  = ram.ram_q;
          state_next = S_START_BIT;
        end
      end
      S_START_BIT: if (bit_tick) state_next = S_DATA_BITS;
      S_DATA_BITS: begin
        rd_en = data_first && !fetched_last;
        if (bit_tick && last_data_bit) state_next = S_STOP_BIT;
      end
      S_STOP_BIT: begin
        if (frame_done) begin
          if (pf_valid) begin
            load       = 1'b1;
            load_byte  = pf_data;
            state_next = S_START_BIT;
          end else begin
`ifdef SENDER_CHECKSUM_EN
            load       = 1'b1;
            load_byte  = cksum;
            cksum_load = 1'b1;
            state_next = S_CKSUM_LOAD;
`else
            state_next = S_FINISH;
`endif
          end
        end
      end
`ifdef SENDER_CHECKSUM_EN
      // Held while the checksum frame plays out on the line.
      S_CKSUM_LOAD: if (frame_done) state_next = S_FINISH;
`endif
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Address counter, read-latency tracking and the one-byte prefetch buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr         <= '0;
      fetched_last <= 1'b0;
      rd_pending   <= 1'b0;
      lat_cnt      <= '0;
      data_first   <= 1'b0;
      pf_valid     <= 1'b0;
      pf_data      <= '0;
    end else begin
      data_first <= (state == S_START_BIT) && bit_tick;
      if ((state == S_IDLE) && start) begin
        addr         <= '0;
        fetched_last <= 1'b0;
        rd_pending   <= 1'b0;
        lat_cnt      <= '0;
        pf_valid     <= 1'b0;
      end else if (rd_en) begin
        rd_pending <= 1'b1;
        lat_cnt    <= 2'd1;
        // Stop at the last address rather than wrapping.
        if (addr == ADDR_LAST) begin
          fetched_last <= 1'b1;
        end else begin
          addr <= addr + ADDR_W'(1);
        end
      end else if (capture) begin
        rd_pending <= 1'b0;
        if (state != S_PRIME) begin
          pf_data  <= ram.ram_q;
          pf_valid <= 1'b1;
        end
      end else if (rd_pending) begin
        lat_cnt <= lat_cnt + 2'd1;
      end
      if ((state == S_STOP_BIT) && frame_done && pf_valid) begin
        pf_valid <= 1'b0;
      end
    end
  end

`ifdef SENDER_CHECKSUM_EN
  // Running mod-256 sum of image bytes as they enter the shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cksum <= '0;
    end else if ((state == S_IDLE) && start) begin
      cksum <= '0;
    end else if (load && !cksum_load) begin
      cksum <= cksum + load_byte;
    end
  end
`endif

  assign ram.ram_addr  = addr;
  assign ram.ram_rd_en = rd_en;
  assign busy          = (state != S_IDLE) && (state != S_FINISH);
  assign done          = (state == S_FINISH);
  assign state_dbg     = state;

endmodule
